indicator_seq_ctrl: RTL and testbench

INDICATOR_SEQ_CTRL -- requirements
Module: indicator_seq_ctrl

---
 rtl/indicator_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_indicator_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/indicator_seq_ctrl.sv
// One-hot indicator sequencer with configurable step period, direction and one-shot/continuous mode.
// Optional macro INDSEQ_BOUNCE_EN makes continuous mode ping-pong between the end positions.
module indicator_seq_ctrl #(
    parameter int N     = 3,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_period,
    input  logic             cfg_dir,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    output logic [N-1:0]     indicators,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    localparam logic [N-1:0] POS_LO = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] POS_HI = {1'b1, {(N-1){1'b0}}};

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] period_q;
    logic             dir_q, oneshot_q;
    logic [N-1:0]     ind_nxt;
    logic             xfer, start_dir, cur_dir, at_last;

`ifdef INDSEQ_BOUNCE_EN
    // Running direction is separate from dir_q so bouncing never alters the stored configuration.
    logic run_dir, run_dir_nxt;
    assign cur_dir = run_dir;
`else
    assign cur_dir = dir_q;
`endif

    assign cfg_ready = (state == IDLE);
    assign busy      = (state == RUN) || (state == HOLD);
    assign done      = (state == DONE);
    assign xfer      = cfg_valid && cfg_ready;
    assign start_dir = xfer ? cfg_dir : dir_q;
    assign at_last   = cur_dir ? indicators[0] : indicators[N-1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ind_nxt   = indicators;
`ifdef INDSEQ_BOUNCE_EN
        run_dir_nxt = run_dir;
`endif
        if (stop) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            ind_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                        ind_nxt   = start_dir ? POS_HI : POS_LO;
`ifdef INDSEQ_BOUNCE_EN
                        run_dir_nxt = start_dir;
`endif
                    end
                end
                RUN, HOLD: begin
                    // Pause freezes the step in the same cycle it is seen; release resumes at once.
                    if (pause) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = RUN;
                        if (cnt == period_q) begin
                            cnt_nxt = '0;
                            if (!at_last) begin
                                ind_nxt = cur_dir ? (indicators >> 1) : (indicators << 1);
                            end else if (oneshot_q) begin
                                state_nxt = DONE;
                                ind_nxt   = '0;
                            end else begin
`ifdef INDSEQ_BOUNCE_EN
                                run_dir_nxt = ~cur_dir;
                                ind_nxt     = cur_dir ? (indicators << 1) : (indicators >> 1);
`else
                                ind_nxt = cur_dir ? POS_HI : POS_LO;
`endif
                            end
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    ind_nxt   = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    ind_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            indicators <= '0;
            period_q   <= '0;
            dir_q      <= 1'b0;
            oneshot_q  <= 1'b0;
`ifdef INDSEQ_BOUNCE_EN
            run_dir    <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            indicators <= ind_nxt;
            if (xfer) begin
                period_q  <= cfg_period;
                dir_q     <= cfg_dir;
                oneshot_q <= cfg_oneshot;
            end
`ifdef INDSEQ_BOUNCE_EN
            run_dir    <= run_dir_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_indicator_seq_ctrl.sv
// Bench for indicator_seq_ctrl: index-based reference model checked every cycle, plus directed literal checks.
module tb_indicator_seq_ctrl;

    localparam int N     = 3;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_period;
    logic             cfg_dir;
    logic             cfg_oneshot;
    logic             start;
    logic             stop;
    logic             pause;
    logic [N-1:0]     indicators;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    indicator_seq_ctrl #(.N(N), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_dir(cfg_dir), .cfg_oneshot(cfg_oneshot),
        .start(start), .stop(stop), .pause(pause),
        .indicators(indicators), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position as an index, run as a flag, plain integer counting.
    int m_active, m_done, m_pos, m_dir, m_cnt, m_period, m_cfgdir, m_oneshot;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 0; m_done <= 0; m_pos <= 0; m_dir <= 0;
            m_cnt <= 0; m_period <= 0; m_cfgdir <= 0; m_oneshot <= 0;
        end else begin : step
            int act, dn, pos, dir, cnt, per, cdir, osh, nxt, idle;
            act = m_active; dn = m_done; pos = m_pos; dir = m_dir;
            cnt = m_cnt; per = m_period; cdir = m_cfgdir; osh = m_oneshot;
            idle = (act == 0 && dn == 0) ? 1 : 0;
            if (idle != 0 && cfg_valid) begin
                per = int'(cfg_period); cdir = int'(cfg_dir); osh = int'(cfg_oneshot);
            end
            if (stop) begin
                act = 0; dn = 0; cnt = 0;
            end else if (dn != 0) begin
                dn = 0;
            end else if (idle != 0) begin
                if (start) begin
                    act = 1; dir = cdir; pos = (dir != 0) ? N - 1 : 0; cnt = 0;
                end
            end else if (!pause) begin
                if (cnt < per) begin
                    cnt = cnt + 1;
                end else begin
                    cnt = 0;
                    nxt = (dir != 0) ? pos - 1 : pos + 1;
                    if (nxt >= 0 && nxt < N) begin
                        pos = nxt;
                    end else if (osh != 0) begin
                        act = 0; dn = 1;
                    end else begin
`ifdef INDSEQ_BOUNCE_EN
                        dir = (dir != 0) ? 0 : 1;
                        pos = (dir != 0) ? pos - 1 : pos + 1;
`else
                        pos = (dir != 0) ? N - 1 : 0;
`endif
                    end
                end
            end
            m_active <= act; m_done <= dn; m_pos <= pos; m_dir <= dir;
            m_cnt <= cnt; m_period <= per; m_cfgdir <= cdir; m_oneshot <= osh;
        end
    end

    always @(negedge clk) begin
        chk("model_indicators", int'(indicators), (m_active != 0) ? (1 << m_pos) : 0);
        chk("model_busy", int'(busy), m_active);
        chk("model_done", int'(done), m_done);
        chk("model_cfg_ready", int'(cfg_ready), (m_active == 0 && m_done == 0) ? 1 : 0);
    end

    task automatic clear_inputs();
        cfg_valid = 0; cfg_period = '0; cfg_dir = 0; cfg_oneshot = 0;
        start = 0; stop = 0; pause = 0;
    endtask

    task automatic go_idle();
        @(negedge clk);
        clear_inputs();
        stop = 1;
        @(negedge clk);
        stop = 0;
    endtask

    task automatic offer(input int per, input int dir, input int osh);
        cfg_valid = 1; cfg_period = DIV_W'(per); cfg_dir = dir[0]; cfg_oneshot = osh[0];
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        chk("reset_ind", int'(indicators), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 0;
        @(negedge clk);
        chk("post_reset_ind", int'(indicators), 0);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_done", int'(done), 0);
        chk("post_reset_ready", int'(cfg_ready), 1);

        // Continuous, period 2, ascending.
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 1)
                chk("p2_seq", int'(indicators), (c <= 3) ? 1 : (c <= 6) ? 2 : (c <= 9) ? 4 : 1);
            clear_inputs();
            if (c == 0) begin offer(2, 0, 0); start = 1; end
        end
        go_idle();

        // One-shot, period 0, descending.
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= 4)
                chk("oneshot_seq", int'(indicators), (c == 1) ? 4 : (c == 2) ? 2 : (c == 3) ? 1 : 0);
            if (c == 4) chk("oneshot_done", int'(done), 1);
            if (c == 5) begin
                chk("oneshot_idle_busy", int'(busy), 0);
                chk("oneshot_idle_done", int'(done), 0);
                chk("oneshot_idle_ready", int'(cfg_ready), 1);
            end
            clear_inputs();
            if (c == 0) begin offer(0, 1, 1); start = 1; end
        end
        go_idle();

        // Period 3 with a 5-cycle pause while showing 010, then stop during HOLD.
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            if (c >= 1)
                chk("pause_seq", int'(indicators),
                    (c <= 4) ? 1 : (c <= 13) ? 2 : (c <= 16) ? 4 : 0);
            if (c == 8) chk("pause_busy", int'(busy), 1);
            if (c == 17) chk("stop_hold_busy", int'(busy), 0);
            clear_inputs();
            if (c == 0) begin offer(3, 0, 0); start = 1; end
            pause = ((c >= 6 && c <= 10) || c == 15 || c == 16);
            stop  = (c == 16);
        end
        go_idle();

        // start+stop in IDLE, start ignored in RUN, cfg offer ignored in RUN.
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("startstop_busy", int'(busy), 0);
                chk("startstop_ready", int'(cfg_ready), 1);
            end
            if (c >= 2)
                chk("run_ignore_seq", int'(indicators), (c <= 3) ? 1 : (c <= 5) ? 2 : 4);
            if (c == 3) chk("run_ready", int'(cfg_ready), 0);
            clear_inputs();
            if (c == 0) begin start = 1; stop = 1; end
            if (c == 1) begin offer(1, 0, 0); start = 1; end
            if (c == 3) begin offer(7, 1, 1); start = 1; end
        end
        go_idle();

        // Period 0 continuous: wrap or bounce at the end.
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
`ifdef INDSEQ_BOUNCE_EN
            if (c >= 1)
                chk("end_seq", int'(indicators), (c == 1) ? 1 : (c == 2) ? 2 : (c == 3) ? 4 : (c == 4) ? 2 : 1);
`else
            if (c >= 1)
                chk("end_seq", int'(indicators), (c == 1) ? 1 : (c == 2) ? 2 : (c == 3) ? 4 : (c == 4) ? 1 : 2);
`endif
            clear_inputs();
            if (c == 0) begin offer(0, 0, 0); start = 1; end
        end

        // Asynchronous reset mid-run clears outputs without a clock edge.
        @(negedge clk);
        clear_inputs();
        #2 reset = 1;
        #1;
        chk("async_reset_ind", int'(indicators), 0);
        chk("async_reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("async_release_ready", int'(cfg_ready), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            stop        = ($urandom % 40) == 0;
            start       = ($urandom % 8) == 0;
            pause       = ($urandom % 6) == 0;
            cfg_valid   = ($urandom % 3) == 0;
            cfg_period  = DIV_W'($urandom % 4);
            cfg_dir     = $urandom % 2;
            cfg_oneshot = $urandom % 2;
        end
        go_idle();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
